// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared encodings and alignment helper for the data memory controller
package data_mem_pkg;

  // Access size encodings carried on the size port
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Controller FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // True when the access cannot be served: odd half, unaligned word, or reserved size
  function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian byte-lane steering for loads and stores
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_wdata_lanes,
  output logic [3:0]  o_byte_en
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load side: pick the addressed lane (lowest address = MSB lane) and extend it
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_load = i_word;
    case (i_offset)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];
    case (i_size)
      SZ_BYTE: o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_word;
    endcase
  end

  // Store side: replicate the data across lanes so the byte enables alone select the target
  always_comb begin
    o_byte_en     = 4'b0000;
    o_wdata_lanes = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_byte_en     = 4'b1000 >> i_offset;
        o_wdata_lanes = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_byte_en     = i_offset[1] ? 4'b0011 : 4'b1100;
        o_wdata_lanes = {2{i_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_byte_en     = 4'b1111;
        o_wdata_lanes = i_wdata;
      end
      default: begin
        o_byte_en     = 4'b0000;
        o_wdata_lanes = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-addressable big-endian data RAM with valid/ready and programmable latency
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int MEM_BYTES     = 2048,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        resp_valid,
  output logic        resp_error
);

  localparam int ADDR_BITS = $clog2(MEM_BYTES);
  localparam int MAX_LAT   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W     = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_rd;
  logic                 r_wr;
  logic [ADDR_BITS-1:0] r_addr;
  logic [1:0]           r_size;
  logic                 r_uns;
  logic [31:0]          r_wdata;
  logic                 r_err;
  logic [31:0]          r_read_data;
  logic [7:0]           r_mem [MEM_BYTES];

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_rd;
  logic                 w_wr;
  logic [ADDR_BITS-1:0] w_idx;
  logic [1:0]           w_size;
  logic                 w_uns;
  logic [31:0]          w_wdata;
  logic                 w_err;
  logic [CNT_W-1:0]     w_cnt_load;
  logic                 w_enter_resp;
  logic                 w_do_store;
  logic                 w_do_load;
  logic [ADDR_BITS-3:0] w_word_hi;
  logic [31:0]          w_word;
  logic [31:0]          w_load;
  logic [31:0]          w_wdata_lanes;
  logic [3:0]           w_byte_en;
  logic                 w_unused_addr;

  // Upper address bits are deliberately dropped so accesses wrap around the RAM
  assign w_unused_addr = ^address[31:ADDR_BITS];

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle && req_valid;
  assign req_ready = w_idle;

  // With latency 1 the commit edge is the accept edge, so the live inputs stand in for the latched request
  assign w_rd    = w_idle ? MemRead                  : r_rd;
  assign w_wr    = w_idle ? MemWrite                 : r_wr;
  assign w_idx   = w_idle ? address[ADDR_BITS-1:0]   : r_addr;
  assign w_size  = w_idle ? size                     : r_size;
  assign w_uns   = w_idle ? load_unsigned            : r_uns;
  assign w_wdata = w_idle ? write_data               : r_wdata;

  // A request with no operation is a harmless no-op, so alignment only matters when something is accessed
  assign w_err = (w_rd && w_wr) || ((w_rd || w_wr) && f_misaligned(w_size, w_idx[1:0]));

  assign w_cnt_load   = (MemWrite && !MemRead) ? WR_LOAD : RD_LOAD;
  assign w_enter_resp = (w_accept && (w_cnt_load == '0)) ||
                        ((r_state == ST_BUSY) && (r_cnt == CNT_W'(1)));
  assign w_do_store   = w_enter_resp && w_wr && !w_rd && !w_err;
  assign w_do_load    = w_enter_resp && w_rd && !w_wr && !w_err;

  // Aligned word containing the addressed byte; lowest address is the most significant byte
  assign w_word_hi = w_idx[ADDR_BITS-1:2];
  assign w_word    = {r_mem[{w_word_hi, 2'd0}], r_mem[{w_word_hi, 2'd1}],
                      r_mem[{w_word_hi, 2'd2}], r_mem[{w_word_hi, 2'd3}]};

  mem_lane_align u_lane_align (
    .i_offset      (w_idx[1:0]),
    .i_size        (w_size),
    .i_unsigned    (w_uns),
    .i_word        (w_word),
    .i_wdata       (w_wdata),
    .o_load        (w_load),
    .o_wdata_lanes (w_wdata_lanes),
    .o_byte_en     (w_byte_en)
  );

  // FSM and latency counter: IDLE accepts, BUSY counts down, RESP lasts one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt   <= w_cnt_load;
            r_state <= (w_cnt_load == '0) ? ST_RESP : ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture the request at the handshake so later input changes are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rd    <= MemRead;
      r_wr    <= MemWrite;
      r_addr  <= address[ADDR_BITS-1:0];
      r_size  <= size;
      r_uns   <= load_unsigned;
      r_wdata <= write_data;
      r_err   <= w_err;
    end
  end

  // Load result register; only successful loads change it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data <= '0;
    end else if (w_do_load) begin
      r_read_data <= w_load;
    end
  end

  // RAM write port; contents survive reset, and a reset on the commit edge suppresses the write
  always_ff @(posedge clk) begin
    if (!reset && w_do_store) begin
      for (int k = 0; k < 4; k++) begin
        if (w_byte_en[3-k]) begin
          r_mem[{w_word_hi, 2'(k)}] <= w_wdata_lanes[31-8*k -: 8];
        end
      end
    end
  end

  assign read_data  = r_read_data;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_error = (r_state == ST_RESP) && r_err;

endmodule
